// File: rtl/alu_op_sequencer_if.sv
// Request/ALU/response bundle for alu_op_sequencer.
//   req_*  : operation request (valid/ready), aluop/funct decode inputs, operands, tag
//   alu_*  : operands and control toward the ALU, result and flags back from it
//   rsp_*  : tagged response (valid/ready) carrying captured result and flags
// Modports: slave = the sequencer, master = the decode stage / ALU / consumer side.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_cout;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, req_tag,
    output req_ready,
    output alu_src1, alu_src2, alu_ctrl,
    input  alu_result, alu_zero, alu_cout, alu_overflow,
    output rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_tag, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, req_tag,
    input  req_ready,
    input  alu_src1, alu_src2, alu_ctrl,
    output alu_result, alu_zero, alu_cout, alu_overflow,
    input  rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_tag, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issuing side of the ALU datapath: accepts a request, decodes ALUOp/funct into the 4-bit
// ALU control code, drives the ALU, waits out its registered latency, captures result and
// flags, and returns them as a tagged response.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous reset, active HIGH despite the name
//   bus    : alu_op_sequencer_if.slave (req_*, alu_*, rsp_* groups)
//   stat_ops, stat_ovf : saturating response / overflow-response counters, present only
//                        when ALU_SEQ_STATS_EN is defined
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_ovf
`endif
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;

  // Counter only has to hold ALU_LAT-1.
  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             addsub_q, addsub_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       dec_ctrl;
  logic             dec_legal;
  logic             req_ready;
  logic             rsp_valid;

  always_comb begin
    dec_ctrl  = CtrlAnd;
    dec_legal = 1'b0;
    case (bus.req_aluop)
      2'b00: begin dec_ctrl = CtrlAdd; dec_legal = 1'b1; end
      2'b01: begin dec_ctrl = CtrlSub; dec_legal = 1'b1; end
      2'b10: begin
        case (bus.req_funct)
          6'b100000: begin dec_ctrl = CtrlAdd; dec_legal = 1'b1; end
          6'b100010: begin dec_ctrl = CtrlSub; dec_legal = 1'b1; end
          6'b100100: begin dec_ctrl = CtrlAnd; dec_legal = 1'b1; end
          6'b100101: begin dec_ctrl = CtrlOr;  dec_legal = 1'b1; end
          6'b100111: begin dec_ctrl = CtrlNor; dec_legal = 1'b1; end
          6'b101010: begin dec_ctrl = CtrlSlt; dec_legal = 1'b1; end
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    ctrl_d    = ctrl_q;
    tag_d     = tag_q;
    addsub_d  = addsub_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          tag_d = bus.req_tag;
          if (dec_legal) begin
            src1_d   = bus.req_a;
            src2_d   = bus.req_b;
            ctrl_d   = dec_ctrl;
            addsub_d = (dec_ctrl == CtrlAdd) || (dec_ctrl == CtrlSub);
            state_d  = StIssue;
          end else begin
            // Illegal ops never touch the ALU; answer immediately with a zeroed payload.
            result_d  = '0;
            zero_d    = 1'b0;
            cout_d    = 1'b0;
            ovf_d     = 1'b0;
            illegal_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StIssue: begin
        cnt_d   = CntW'(ALU_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          result_d  = bus.alu_result;
          zero_d    = bus.alu_zero;
          // Carry and overflow only mean something for add/sub.
          cout_d    = addsub_q & bus.alu_cout;
          ovf_d     = addsub_q & bus.alu_overflow;
          illegal_d = 1'b0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= StIdle;
      src1_q    <= '0;
      src2_q    <= '0;
      ctrl_q    <= '0;
      tag_q     <= '0;
      addsub_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      ctrl_q    <= ctrl_d;
      tag_q     <= tag_d;
      addsub_q  <= addsub_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.alu_src1     = src1_q;
  assign bus.alu_src2     = src2_q;
  assign bus.alu_ctrl     = ctrl_q;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_cout     = cout_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_tag      = tag_q;
  assign bus.rsp_illegal  = illegal_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] ops_q, ops_d;
  logic [15:0] ovfc_q, ovfc_d;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid & bus.rsp_ready;

  always_comb begin
    ops_d  = ops_q;
    ovfc_d = ovfc_q;
    if (rsp_hs && (ops_q != 16'hFFFF)) ops_d = ops_q + 16'd1;
    if (rsp_hs && ovf_q && (ovfc_q != 16'hFFFF)) ovfc_d = ovfc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ops_q  <= '0;
      ovfc_q <= '0;
    end else begin
      ops_q  <= ops_d;
      ovfc_q <= ovfc_d;
    end
  end

  assign stat_ops = ops_q;
  assign stat_ovf = ovfc_q;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing side of the 32-bit ALU datapath interface.
- Accepts operation requests over a valid/ready handshake and decodes ALUOp/funct into the 4-bit ALU control code.
- Drives ALU operands and control, waits out the ALU's registered latency, then captures result and flags.
- Returns the captured values as a tagged response over a second valid/ready handshake. Sits between the instruction-decode stage and the ALU.

Parameters:
- WIDTH, 32: operand/result width.
- ALU_LAT, 1: cycles the ALU needs after its capture edge before result and flags are stable. Minimum 1.
- TAG_W, 4: request/response tag width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-high (asserted = 1) despite the name
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
- req_funct  in  6  R-type funct field
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_tag  in  TAG_W  request tag
- alu_src1  out  WIDTH  ALU source 1
- alu_src2  out  WIDTH  ALU source 2
- alu_ctrl  out  4  ALU control code
- alu_result  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- alu_cout  in  1  ALU carry-out
- alu_overflow  in  1  ALU overflow flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- rsp_cout  out  1  captured carry-out (masked)
- rsp_overflow  out  1  captured overflow (masked)
- rsp_tag  out  TAG_W  echoed tag
- rsp_illegal  out  1  undecodable request

Behaviour:
- One clock. Synchronous, active-high reset on rst_n.
- Reset values: state IDLE; all outputs 0, including alu_src1, alu_src2, alu_ctrl=0000, and every rsp_* output. Reset in any state abandons the in-flight operation; no response is ever produced for it.
- Decode:
  - aluop 00 -> 0010; aluop 01 -> 0110.
  - aluop 10 with funct 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 100111 -> 1100 (nor), 101010 -> 0111 (slt).
  - Any other funct, or aluop 11, is illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid&&req_ready.
  - Legal request: register alu_src1=req_a, alu_src2=req_b, alu_ctrl=decoded code, latch tag and op class; go to ISSUE.
  - Illegal request: leave alu_* unchanged; load rsp_result=0, zero/cout/overflow=0, rsp_illegal=1; go directly to RESP.
- ISSUE: one cycle. The ALU captures operands at the exiting edge. Go to WAIT; load wait counter with ALU_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge where the counter is 0, capture into rsp_*: result, zero, cout, overflow; rsp_illegal=0. Go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE; rsp_valid deasserts the next cycle.
- req_ready=0 in every state except IDLE. A back-to-back stream therefore costs one IDLE cycle between responses.
- alu_src1, alu_src2 and alu_ctrl change only on a legal accept; they hold through WAIT, RESP and IDLE.
- Latency, accept edge to first rsp_valid cycle:
  - Legal request: ALU_LAT+2 cycles.
  - Illegal request: 1 cycle.
- Flag masking: rsp_cout and rsp_overflow pass the ALU flags only for add/sub codes (0010, 0110); otherwise they are 0. rsp_zero is always passed through.
- No internal queuing; exactly one operation is in flight.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, the block adds output ports stat_ops[15:0] and stat_ovf[15:0]. Both reset to 0 on rst_n.
  - stat_ops increments on each response handshake (rsp_valid&&rsp_ready).
  - stat_ovf increments on each response handshake with rsp_overflow=1.
  - Both saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- aluop=10, funct=100000, a=5, b=7, rsp_ready=1 -> alu_ctrl=0010; rsp_result=12, zero=0, overflow=0; rsp_valid 3 cycles after accept (ALU_LAT=1).
- aluop=01, a=b=0x00001234 -> alu_ctrl=0110, rsp_result=0, rsp_zero=1.
- add with a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_overflow=1. Then funct=100100 with the same operands -> rsp_result=1, rsp_overflow=0, rsp_cout=0.
- aluop=10, funct=000000, tag=9 -> rsp_illegal=1, rsp_result=0, rsp_tag=9; rsp_valid 1 cycle after accept; alu_ctrl unchanged from the prior op.
- rsp_ready held 0 for 5 cycles during RESP -> rsp_* stable, req_ready=0 throughout. Release -> IDLE next cycle, next request accepted.
- rst_n pulsed high during WAIT -> all outputs 0 next cycle, state IDLE, no response for that tag. The following request completes normally.
